// File: rtl/meteor_fetch_arbiter.sv
// rtl/meteor_fetch_arbiter.sv - round-robin meteor sprite fetch arbiter with ROM/palette pipeline
//
// Ports:
//   Clk             in   system clock, rising edge
//   Reset           in   asynchronous active-high reset
//   en              in   permits new grants (in-flight results keep draining when low)
//   req             in   per-requester fetch request, held until granted
//   req_addr        in   flattened per-requester ROM address, requester i at [i*ADDR_W +: ADDR_W]
//   gnt             out  registered one-hot grant, one cycle wide
//   rom_addr        out  registered address to the synchronous sprite ROM
//   rom_data        in   ROM palette index, valid one cycle after rom_addr
//   pal_index       out  combinational copy of rom_data to the shared palette
//   pal_red/green/blue in combinational palette result
//   out_valid       out  result valid
//   out_id          out  requester that owns the result
//   out_rgb         out  {red, green, blue}
//   out_transparent out  fetched palette index was 0
module meteor_fetch_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [3:0]                rom_data,
    output logic [3:0]                pal_index,
    input  logic [3:0]                pal_red,
    input  logic [3:0]                pal_green,
    input  logic [3:0]                pal_blue,
    output logic                      out_valid,
    output logic [ID_W-1:0]           out_id,
    output logic [11:0]               out_rgb,
    output logic                      out_transparent
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    next_ptr;
    int                 cand;

    // S0 id rides alongside gnt; S1 covers the ROM read cycle.
    logic [ID_W-1:0]    s0_id;
    logic               s1_valid;
    logic [ID_W-1:0]    s1_id;

    // A requester granted last cycle still has req high (it drops req only
    // after seeing gnt), so mask it for one cycle to avoid a double grant.
    assign eligible = req & ~gnt & {NUM_REQ{en}};

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    assign pal_index = rom_data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gnt             <= '0;
            rom_addr        <= '0;
            rr_ptr          <= '0;
            s0_id           <= '0;
            s1_valid        <= 1'b0;
            s1_id           <= '0;
            out_valid       <= 1'b0;
            out_id          <= '0;
            out_rgb         <= '0;
            out_transparent <= 1'b0;
        end else begin
            // S0: grant and ROM address
            gnt <= found ? (NUM_REQ'(1) << win_id) : '0;
            if (found) begin
                rom_addr <= req_addr[win_id*ADDR_W +: ADDR_W];
                rr_ptr   <= next_ptr;
                s0_id    <= win_id;
            end

            // S1: ROM read in progress, palette lookup is combinational
            s1_valid <= |gnt;
            s1_id    <= s0_id;

            // S2: output register; data holds when nothing is valid
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_rgb         <= {pal_red, pal_green, pal_blue};
                out_id          <= s1_id;
                out_transparent <= (rom_data == 4'd0);
            end
        end
    end

endmodule
